// File: rtl/mult_result_bcd_if.sv
// Product hand-off and decimal result bus between the multiplier and the BCD converter.
interface mult_result_bcd_if #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DIGITS = 3
);
   logic [WIDTH-1:0]    mp_in;
   logic                mp_valid;
   logic                in_ready;
   logic [4*DIGITS-1:0] bcd_out;
   logic [DIGITS-1:0]   blank;
   logic                done;

   modport master (
      output mp_in, mp_valid,
      input  in_ready, bcd_out, blank, done
   );

   modport slave (
      input  mp_in, mp_valid,
      output in_ready, bcd_out, blank, done
   );
endinterface

// File: rtl/mult_result_bcd.sv
// Captures a binary product and converts it to packed BCD with double-dabble, one bit per clock,
// holding the result and leading-zero blank flags for the display stage.
module mult_result_bcd #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DIGITS = 3,
   parameter int unsigned CNTW   = 4
) (
   input logic             sys_clk,
   input logic             sys_rst,
   mult_result_bcd_if.slave bus
);
   localparam int unsigned BCDW = 4 * DIGITS;

   typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

   state_t            state, state_n;
   logic [WIDTH-1:0]  bin_sr, bin_n;
   logic [BCDW-1:0]   bcd_sr, bcd_n;
   logic [CNTW-1:0]   cnt, cnt_n;
   logic [BCDW-1:0]   bcd_out_q, bcd_out_n;
   logic [DIGITS-1:0] blank_q, blank_n;
   logic              done_q, done_n;
   logic              in_ready_q, in_ready_n;

   logic [BCDW-1:0]   adj_c;
   logic [BCDW-1:0]   shifted_c;
   logic [DIGITS-1:0] blank_c;

   // Add-3 correction per digit, no carry between digits
   always_comb begin
      logic [3:0] dig;
      adj_c = '0;
      dig   = '0;
      for (int d = 0; d < int'(DIGITS); d++) begin
         dig = bcd_sr[4*d +: 4];
         adj_c[4*d +: 4] = (dig >= 4'd5) ? 4'(dig + 4'd3) : dig;
      end
      shifted_c = {adj_c[BCDW-2:0], bin_sr[WIDTH-1]};
   end

   // A digit blanks only while it and every digit above it are zero; the ones digit never blanks
   always_comb begin
      logic zero_run;
      blank_c  = '0;
      zero_run = 1'b1;
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
         zero_run   = zero_run & (shifted_c[4*i +: 4] == 4'd0);
         blank_c[i] = zero_run;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state      <= IDLE;
         bin_sr     <= '0;
         bcd_sr     <= '0;
         cnt        <= '0;
         bcd_out_q  <= '0;
         blank_q    <= {{(DIGITS-1){1'b1}}, 1'b0};
         done_q     <= 1'b0;
         in_ready_q <= 1'b1;
      end else begin
         state      <= state_n;
         bin_sr     <= bin_n;
         bcd_sr     <= bcd_n;
         cnt        <= cnt_n;
         bcd_out_q  <= bcd_out_n;
         blank_q    <= blank_n;
         done_q     <= done_n;
         in_ready_q <= in_ready_n;
      end
   end

   always_comb begin
      state_n   = state;
      bin_n     = bin_sr;
      bcd_n     = bcd_sr;
      cnt_n     = cnt;
      bcd_out_n = bcd_out_q;
      blank_n   = blank_q;
      done_n    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.mp_valid) begin
               bin_n   = bus.mp_in;
               bcd_n   = '0;
               cnt_n   = CNTW'(WIDTH);
               state_n = CONV;
            end
         end
         CONV: begin
            bcd_n = shifted_c;
            bin_n = {bin_sr[WIDTH-2:0], 1'b0};
            cnt_n = CNTW'(cnt - CNTW'(1));
            if (cnt == CNTW'(1)) begin
               bcd_out_n = shifted_c;
               blank_n   = blank_c;
               done_n    = 1'b1;
               state_n   = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      in_ready_n = (state_n == IDLE);
   end

   assign bus.in_ready = in_ready_q;
   assign bus.bcd_out  = bcd_out_q;
   assign bus.blank    = blank_q;
   assign bus.done     = done_q;
endmodule

// File: tb/tb_mult_result_bcd.sv
// Directed bench for mult_result_bcd: latency, decimal results, blanking, ignored strobes, reset abort.
module tb_mult_result_bcd;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   mult_result_bcd_if #(.WIDTH(8), .DIGITS(3)) bus ();

   mult_result_bcd #(.WIDTH(8), .DIGITS(3), .CNTW(4)) dut (
      .sys_clk (clk),
      .sys_rst (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Pulse one product and wait (bounded) for done; reports result, latency and busy behaviour
   task automatic convert(input logic [7:0] v, output logic [11:0] bcd, output logic [2:0] blk,
                          output int lat, output bit busy_ok);
      @(negedge clk);
      bus.mp_in    = v;
      bus.mp_valid = 1'b1;
      @(negedge clk);
      bus.mp_valid = 1'b0;
      lat     = 0;
      busy_ok = 1'b1;
      while (bus.done !== 1'b1 && lat < 40) begin
         if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      bcd = bus.bcd_out;
      blk = bus.blank;
   endtask

   task automatic test_reset();
      bus.mp_in = 8'h00; bus.mp_valid = 1'b0; rst = 1'b1;
      repeat (2) @(negedge clk);
      tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
      tests++; if (bus.bcd_out !== 12'h000) begin fails++; $display("FAIL reset_bcd got %h want 000", bus.bcd_out); end
      tests++; if (bus.blank !== 3'b110) begin fails++; $display("FAIL reset_blank got %b want 110", bus.blank); end
      tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.done); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_zero();
      logic [11:0] bcd; logic [2:0] blk; int lat; bit busy_ok;
      convert(8'h00, bcd, blk, lat, busy_ok);
      tests++; if (lat !== 8) begin fails++; $display("FAIL zero_latency got %0d want 8", lat); end
      tests++; if (bcd !== 12'h000) begin fails++; $display("FAIL zero_bcd got %h want 000", bcd); end
      tests++; if (blk !== 3'b110) begin fails++; $display("FAIL zero_blank got %b want 110", blk); end
      tests++; if (!busy_ok) begin fails++; $display("FAIL zero_busy in_ready got 1 want 0 during conversion"); end
      tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL zero_ready_at_done got %b want 1", bus.in_ready); end
      @(negedge clk);
      tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL zero_done_width got %b want 0", bus.done); end
   endtask

   task automatic test_values();
      logic [7:0]  vin  [5] = '{8'hE1, 8'hFF, 8'h09, 8'h64, 8'h2A};
      logic [11:0] vbcd [5] = '{12'h225, 12'h255, 12'h009, 12'h100, 12'h042};
      logic [2:0]  vblk [5] = '{3'b000, 3'b000, 3'b110, 3'b000, 3'b100};
      logic [11:0] bcd; logic [2:0] blk; int lat; bit busy_ok;
      for (int k = 0; k < 5; k++) begin
         convert(vin[k], bcd, blk, lat, busy_ok);
         tests++; if (bcd !== vbcd[k]) begin fails++; $display("FAIL value_bcd in=%h got %h want %h", vin[k], bcd, vbcd[k]); end
         tests++; if (blk !== vblk[k]) begin fails++; $display("FAIL value_blank in=%h got %b want %b", vin[k], blk, vblk[k]); end
         tests++; if (lat !== 8) begin fails++; $display("FAIL value_latency in=%h got %0d want 8", vin[k], lat); end
         @(negedge clk);
         tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL value_done_width in=%h got %b want 0", vin[k], bus.done); end
         tests++; if (bus.bcd_out !== vbcd[k]) begin fails++; $display("FAIL value_hold in=%h got %h want %h", vin[k], bus.bcd_out, vbcd[k]); end
      end
   endtask

   task automatic test_ignore_strobe();
      int lat; int extra;
      @(negedge clk);
      bus.mp_in = 8'h51; bus.mp_valid = 1'b1;
      @(negedge clk);
      bus.mp_valid = 1'b0; lat = 0;
      while (bus.done !== 1'b1 && lat < 40) begin
         if (lat == 2) begin bus.mp_in = 8'h07; bus.mp_valid = 1'b1; end
         else bus.mp_valid = 1'b0;
         @(negedge clk);
         lat++;
      end
      bus.mp_valid = 1'b0;
      tests++; if (lat !== 8) begin fails++; $display("FAIL ignore_latency got %0d want 8", lat); end
      tests++; if (bus.bcd_out !== 12'h081) begin fails++; $display("FAIL ignore_bcd got %h want 081", bus.bcd_out); end
      extra = 0;
      repeat (15) begin @(negedge clk); if (bus.done === 1'b1) extra++; end
      tests++; if (extra !== 0) begin fails++; $display("FAIL ignore_second_done got %0d pulses want 0", extra); end
   endtask

   task automatic test_reset_mid();
      logic [11:0] bcd; logic [2:0] blk; int lat; bit busy_ok; int seen;
      @(negedge clk);
      bus.mp_in = 8'hC8; bus.mp_valid = 1'b1;
      @(negedge clk);
      bus.mp_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      tests++; if (bus.bcd_out !== 12'h000) begin fails++; $display("FAIL abort_bcd got %h want 000", bus.bcd_out); end
      tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL abort_ready got %b want 1", bus.in_ready); end
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      @(negedge clk);
      tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL abort_ready_after got %b want 1", bus.in_ready); end
      repeat (12) begin if (bus.done === 1'b1) seen++; @(negedge clk); end
      tests++; if (seen !== 0) begin fails++; $display("FAIL abort_done got %0d pulses want 0", seen); end
      convert(8'hC8, bcd, blk, lat, busy_ok);
      tests++; if (bcd !== 12'h200) begin fails++; $display("FAIL abort_retry_bcd got %h want 200", bcd); end
      tests++; if (blk !== 3'b000) begin fails++; $display("FAIL abort_retry_blank got %b want 000", blk); end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  vin  [3] = '{8'h10, 8'h63, 8'h90};
      logic [11:0] vbcd [3] = '{12'h016, 12'h099, 12'h144};
      int k; int cyc; int last;
      @(negedge clk);
      bus.mp_in = vin[0]; bus.mp_valid = 1'b1;
      k = 0; cyc = 0; last = 0;
      while (k < 3 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (bus.done === 1'b1) begin
            tests++; if (bus.bcd_out !== vbcd[k]) begin fails++; $display("FAIL b2b_bcd idx=%0d got %h want %h", k, bus.bcd_out, vbcd[k]); end
            if (k > 0) begin
               tests++; if (cyc - last !== 9) begin fails++; $display("FAIL b2b_interval idx=%0d got %0d want 9", k, cyc - last); end
            end
            last = cyc;
            k++;
            if (k < 3) bus.mp_in = vin[k];
            else bus.mp_valid = 1'b0;
         end
      end
      bus.mp_valid = 1'b0;
      tests++; if (k !== 3) begin fails++; $display("FAIL b2b_count got %0d want 3", k); end
      repeat (12) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_zero();
      test_values();
      test_ignore_strobe();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
